// File: rtl/pulse_delay_pkg.sv
// Shared types, constants and the delay clamp for the pulse delay scheduler.
package pulse_delay_pkg;

  localparam int unsigned MIN_DELAY  = 2;
  localparam int unsigned DROP_CNT_W = 8;
  localparam int unsigned CLAMP_W    = 32;

  typedef enum logic {
    IDLE,
    WAIT_DRAIN
  } sched_state_e;

  // A delay below two cycles cannot be honoured by the head-compare pop, so raise it.
  function automatic logic [CLAMP_W-1:0] clamp_delay(input logic [CLAMP_W-1:0] d);
    return (d < CLAMP_W'(MIN_DELAY)) ? CLAMP_W'(MIN_DELAY) : d;
  endfunction

endpackage

// File: rtl/ts_fifo.sv
// Target-timestamp FIFO: synchronous, power-of-two depth, head visible combinationally.
module ts_fifo
  import pulse_delay_pkg::*;
#(
  parameter int unsigned W     = 16,
  parameter int unsigned DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic                         pop,
  input  logic [W-1:0]                 wdata,
  output logic [W-1:0]                 head_c,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;
  logic [CW-1:0] count_nxt;

  // A push into a full FIFO is accepted only when the same edge frees a slot.
  assign do_pop    = pop && !empty;
  assign do_push   = push && (!full || do_pop);
  assign count_nxt = count + CW'(do_push) - CW'(do_pop);
  assign head_c    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_nxt;
      full  <= (count_nxt == CW'(DEPTH));
      empty <= (count_nxt == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/pulse_delay_sched.sv
// Programmable-latency pulse scheduler: each din event re-emerges on dout exactly active_delay cycles later.
// Define PULSE_DELAY_SCHED_DROP_CNT_EN to add the saturating drop_cnt output.
module pulse_delay_sched
  import pulse_delay_pkg::*;
#(
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned DEF_DELAY = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         din,
  input  logic [CNT_W-1:0]             cfg_delay,
  input  logic                         cfg_load,
  output logic                         dout,
  output logic [CNT_W-1:0]             active_delay,
  output logic                         load_pend,
  output logic [$clog2(DEPTH+1)-1:0]   pending_cnt,
  output logic                         busy,
  output logic                         ovf,
  input  logic                         ovf_clr
`ifdef PULSE_DELAY_SCHED_DROP_CNT_EN
  ,
  output logic [DROP_CNT_W-1:0]        drop_cnt
`endif
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  sched_state_e     state;
  logic [CNT_W-1:0] ts;
  logic [CNT_W-1:0] shadow;
  logic [CNT_W-1:0] head_c;
  logic [CNT_W-1:0] push_time_c;
  logic [CNT_W-1:0] cfg_clamped_c;
  logic [CW-1:0]    fifo_count;
  logic             fifo_full;
  logic             fifo_empty;
  logic             pop_c;
  logic             push_c;
  logic             drop_c;
  logic             drain_c;

  // Pop one cycle ahead so the registered dout lands on the target cycle itself.
  assign pop_c         = !fifo_empty && (head_c == ts + CNT_W'(1));
  assign push_c        = din && (!fifo_full || pop_c);
  assign drop_c        = din && fifo_full && !pop_c;
  assign push_time_c   = ts + active_delay;
  assign cfg_clamped_c = CNT_W'(clamp_delay(CLAMP_W'(cfg_delay)));
  assign drain_c       = !busy && !din;

  ts_fifo #(
    .W     (CNT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push   (push_c),
    .pop    (pop_c),
    .wdata  (push_time_c),
    .head_c (head_c),
    .count  (fifo_count),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  // Timestamp, output pulse and occupancy; pending_cnt counts an event until its dout cycle ends.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ts          <= '0;
      dout        <= 1'b0;
      pending_cnt <= '0;
      busy        <= 1'b0;
      ovf         <= 1'b0;
    end else begin
      ts          <= ts + CNT_W'(1);
      dout        <= pop_c;
      pending_cnt <= fifo_count + CW'(push_c);
      busy        <= (fifo_count != '0) || push_c;
      if (drop_c)       ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
    end
  end

  // Delay changes wait for an empty FIFO so stored targets stay in time order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      active_delay <= CNT_W'(DEF_DELAY);
      shadow       <= CNT_W'(DEF_DELAY);
      load_pend    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cfg_load) begin
            if (fifo_empty && !din) begin
              active_delay <= cfg_clamped_c;
            end else begin
              shadow    <= cfg_clamped_c;
              load_pend <= 1'b1;
              state     <= WAIT_DRAIN;
            end
          end
        end
        WAIT_DRAIN: begin
          if (drain_c) begin
            active_delay <= cfg_load ? cfg_clamped_c : shadow;
            load_pend    <= 1'b0;
            state        <= IDLE;
          end else if (cfg_load) begin
            shadow <= cfg_clamped_c;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef PULSE_DELAY_SCHED_DROP_CNT_EN
  // Saturating drop counter; a drop in the clearing cycle restarts the count at one.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      drop_cnt <= '0;
    end else if (drop_c) begin
      if (ovf_clr)              drop_cnt <= DROP_CNT_W'(1);
      else if (drop_cnt != '1)  drop_cnt <= drop_cnt + DROP_CNT_W'(1);
    end else if (ovf_clr) begin
      drop_cnt <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_pulse_delay_sched.sv
// Self-checking bench for pulse_delay_sched: directed scenarios plus randomized traffic against a queue-based model.
module tb_pulse_delay_sched;

  localparam int unsigned CNT_W     = 16;
  localparam int unsigned DEPTH     = 8;
  localparam int unsigned DEF_DELAY = 4;
  localparam int unsigned CW        = $clog2(DEPTH + 1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic             din;
  logic [CNT_W-1:0] cfg_delay;
  logic             cfg_load;
  logic             dout;
  logic [CNT_W-1:0] active_delay;
  logic             load_pend;
  logic [CW-1:0]    pending_cnt;
  logic             busy;
  logic             ovf;
  logic             ovf_clr;

  logic       w_rst_n;
  logic       w_din;
  logic [7:0] w_cfg_delay;
  logic       w_cfg_load;
  logic       w_dout;
  logic [7:0] w_active;
  logic       w_load_pend;
  logic [2:0] w_pending;
  logic       w_busy;
  logic       w_ovf;
`ifdef PULSE_DELAY_SCHED_DROP_CNT_EN
  logic [7:0] drop_cnt;
  logic [7:0] w_drop_cnt;
`endif

  pulse_delay_sched #(.CNT_W(CNT_W), .DEPTH(DEPTH), .DEF_DELAY(DEF_DELAY)) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .din          (din),
    .cfg_delay    (cfg_delay),
    .cfg_load     (cfg_load),
    .dout         (dout),
    .active_delay (active_delay),
    .load_pend    (load_pend),
    .pending_cnt  (pending_cnt),
    .busy         (busy),
    .ovf          (ovf),
    .ovf_clr      (ovf_clr)
`ifdef PULSE_DELAY_SCHED_DROP_CNT_EN
    ,
    .drop_cnt     (drop_cnt)
`endif
  );

  pulse_delay_sched #(.CNT_W(8), .DEPTH(4), .DEF_DELAY(4)) u_wrap (
    .clk          (clk),
    .rst_n        (w_rst_n),
    .din          (w_din),
    .cfg_delay    (w_cfg_delay),
    .cfg_load     (w_cfg_load),
    .dout         (w_dout),
    .active_delay (w_active),
    .load_pend    (w_load_pend),
    .pending_cnt  (w_pending),
    .busy         (w_busy),
    .ovf          (w_ovf),
    .ovf_clr      (1'b0)
`ifdef PULSE_DELAY_SCHED_DROP_CNT_EN
    ,
    .drop_cnt     (w_drop_cnt)
`endif
  );

  // Reference model: absolute fire cycles of accepted events, plus delay/overflow bookkeeping.
  int cyc;
  int mq[$];
  int m_active;
  int m_shadow;
  bit m_pend;
  bit m_ovf;
  int m_dropc;
  int n_checks;
  int n_pass;

  function automatic bit exp_dout();
    foreach (mq[i]) if (mq[i] == cyc) return 1'b1;
    return 1'b0;
  endfunction

  // Advance the model by one clock edge using the current inputs, then step the simulation.
  task automatic tick();
    int in_fifo;
    int pend_now;
    int cl;
    bit pop;
    bit drop;
    in_fifo  = 0;
    pend_now = 0;
    pop      = 1'b0;
    foreach (mq[i]) begin
      if (mq[i] > cyc)      in_fifo++;
      if (mq[i] >= cyc)     pend_now++;
      if (mq[i] == cyc + 1) pop = 1'b1;
    end
    cl = (int'(cfg_delay) < 2) ? 2 : int'(cfg_delay);
    if (!rst_n) begin
      mq.delete();
      m_active = DEF_DELAY;
      m_shadow = DEF_DELAY;
      m_pend   = 1'b0;
      m_ovf    = 1'b0;
      m_dropc  = 0;
    end else begin
      drop = din && (in_fifo == DEPTH) && !pop;
      if (drop)         m_ovf = 1'b1;
      else if (ovf_clr) m_ovf = 1'b0;
      if (drop)         m_dropc = ovf_clr ? 1 : ((m_dropc == 255) ? 255 : m_dropc + 1);
      else if (ovf_clr) m_dropc = 0;
      if (din && !drop) mq.push_back(cyc + m_active);
      if (m_pend) begin
        if (cfg_load) m_shadow = cl;
        if (pend_now == 0 && !din) begin
          m_active = m_shadow;
          m_pend   = 1'b0;
        end
      end else if (cfg_load) begin
        if (in_fifo == 0 && !din) m_active = cl;
        else begin
          m_shadow = cl;
          m_pend   = 1'b1;
        end
      end
    end
    cyc++;
    @(posedge clk);
    @(negedge clk);
    for (int i = mq.size() - 1; i >= 0; i--) if (mq[i] < cyc) mq.delete(i);
  endtask

  task automatic clear_inputs();
    din       = 1'b0;
    cfg_load  = 1'b0;
    cfg_delay = '0;
    ovf_clr   = 1'b0;
  endtask

  task automatic drain();
    int n;
    clear_inputs();
    n = 0;
    while ((mq.size() != 0 || m_pend) && n < 500) begin
      tick();
      n++;
    end
    n_checks++;
    if (n >= 500) $display("FAIL drain_timeout model_events=%0d wanted 0 within 500 cycles", mq.size());
    else n_pass++;
    tick();
    tick();
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n   = 1'b0;
    w_rst_n = 1'b0;
    w_din = 1'b0; w_cfg_load = 1'b0; w_cfg_delay = '0;
    repeat (3) tick();
    rst_n = 1'b1;
    n_checks++; if (dout !== 1'b0) $display("FAIL reset_dout got %b want 0", dout); else n_pass++;
    n_checks++; if (pending_cnt !== '0) $display("FAIL reset_pending got %0d want 0", pending_cnt); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
    n_checks++; if (ovf !== 1'b0) $display("FAIL reset_ovf got %b want 0", ovf); else n_pass++;
    n_checks++; if (load_pend !== 1'b0) $display("FAIL reset_load_pend got %b want 0", load_pend); else n_pass++;
    n_checks++; if (active_delay !== CNT_W'(DEF_DELAY)) $display("FAIL reset_active got %0d want %0d", active_delay, DEF_DELAY); else n_pass++;
  endtask

  task automatic test_single();
    logic [CW-1:0] exp_p;
    for (int r = 0; r <= 20; r++) begin
      din = (r == 10);
      exp_p = (r >= 11 && r <= 14) ? CW'(1) : CW'(0);
      n_checks++; if (dout !== (r == 14)) $display("FAIL single_dout r=%0d got %b want %b", r, dout, r == 14); else n_pass++;
      n_checks++; if (pending_cnt !== exp_p) $display("FAIL single_pending r=%0d got %0d want %0d", r, pending_cnt, exp_p); else n_pass++;
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_long_delay();
    drain();
    for (int r = 0; r <= 360; r++) begin
      cfg_load  = (r == 0);
      cfg_delay = CNT_W'(300);
      din       = (r >= 50 && r <= 52);
      if (r == 1) begin
        n_checks++; if (active_delay !== CNT_W'(300)) $display("FAIL long_active got %0d want 300", active_delay); else n_pass++;
      end
      n_checks++; if (dout !== (r >= 350 && r <= 352)) $display("FAIL long_dout r=%0d got %b want %b", r, dout, r >= 350 && r <= 352); else n_pass++;
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_wrap();
    w_rst_n = 1'b0;
    tick();
    w_rst_n = 1'b1;
    for (int r = 0; r <= 310; r++) begin
      w_cfg_load  = (r == 0);
      w_cfg_delay = 8'd200;
      w_din       = (r == 100);
      if (r == 2) begin
        n_checks++; if (w_active !== 8'd200) $display("FAIL wrap_active got %0d want 200", w_active); else n_pass++;
      end
      if (r == 150) begin
        n_checks++; if (w_pending !== 3'd1 || w_busy !== 1'b1) $display("FAIL wrap_inflight pending=%0d busy=%b want 1 1", w_pending, w_busy); else n_pass++;
      end
      n_checks++; if (w_dout !== (r == 300)) $display("FAIL wrap_dout r=%0d got %b want %b", r, w_dout, r == 300); else n_pass++;
      tick();
    end
    w_cfg_load = 1'b0;
    w_din      = 1'b0;
    n_checks++;
    if (w_pending !== 3'd0 || w_busy !== 1'b0 || w_ovf !== 1'b0 || w_load_pend !== 1'b0)
      $display("FAIL wrap_idle pending=%0d busy=%b ovf=%b load_pend=%b want 0 0 0 0", w_pending, w_busy, w_ovf, w_load_pend);
    else n_pass++;
`ifdef PULSE_DELAY_SCHED_DROP_CNT_EN
    n_checks++; if (w_drop_cnt !== 8'd0) $display("FAIL wrap_drop_cnt got %0d want 0", w_drop_cnt); else n_pass++;
`endif
  endtask

  task automatic test_clamp();
    drain();
    for (int r = 0; r <= 10; r++) begin
      cfg_load  = (r == 0);
      cfg_delay = '0;
      din       = (r == 3);
      if (r == 1) begin
        n_checks++; if (active_delay !== CNT_W'(2)) $display("FAIL clamp_active got %0d want 2", active_delay); else n_pass++;
      end
      n_checks++; if (dout !== (r == 5)) $display("FAIL clamp_dout r=%0d got %b want %b", r, dout, r == 5); else n_pass++;
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_deferred();
    logic exp_d;
    drain();
    for (int r = 0; r <= 32; r++) begin
      cfg_load  = (r == 0 || r == 5);
      cfg_delay = (r == 0) ? CNT_W'(10) : CNT_W'(5);
      din       = (r == 2 || r == 3 || r == 8 || r == 25);
      exp_d     = (r == 12 || r == 13 || r == 18 || r == 30);
      if (r == 6 || r == 19) begin
        n_checks++; if (load_pend !== 1'b1 || active_delay !== CNT_W'(10)) $display("FAIL defer_wait r=%0d load_pend=%b active=%0d want 1 10", r, load_pend, active_delay); else n_pass++;
      end
      if (r == 18) begin
        n_checks++; if (pending_cnt !== CW'(1)) $display("FAIL defer_pending18 got %0d want 1", pending_cnt); else n_pass++;
      end
      if (r == 19) begin
        n_checks++; if (pending_cnt !== CW'(0)) $display("FAIL defer_pending19 got %0d want 0", pending_cnt); else n_pass++;
      end
      if (r == 20) begin
        n_checks++; if (load_pend !== 1'b0 || active_delay !== CNT_W'(5)) $display("FAIL defer_applied load_pend=%b active=%0d want 0 5", load_pend, active_delay); else n_pass++;
      end
      n_checks++; if (dout !== exp_d) $display("FAIL defer_dout r=%0d got %b want %b", r, dout, exp_d); else n_pass++;
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_overflow();
    int pulses;
    drain();
    pulses = 0;
    for (int r = 0; r <= 40; r++) begin
      cfg_load  = (r == 0);
      cfg_delay = CNT_W'(20);
      din       = (r >= 2 && r <= 11);
      ovf_clr   = (r == 11 || r == 13);
      if (r == 10) begin
        n_checks++; if (pending_cnt !== CW'(8) || ovf !== 1'b0) $display("FAIL ovf_full pending=%0d ovf=%b want 8 0", pending_cnt, ovf); else n_pass++;
      end
      if (r == 11 || r == 12) begin
        n_checks++; if (ovf !== 1'b1) $display("FAIL ovf_set r=%0d got %b want 1", r, ovf); else n_pass++;
      end
      if (r == 14) begin
        n_checks++; if (ovf !== 1'b0) $display("FAIL ovf_clear got %b want 0", ovf); else n_pass++;
      end
`ifdef PULSE_DELAY_SCHED_DROP_CNT_EN
      if (r == 12) begin
        n_checks++; if (drop_cnt !== 8'd1) $display("FAIL drop_cnt_clr_wins got %0d want 1", drop_cnt); else n_pass++;
      end
      if (r == 14) begin
        n_checks++; if (drop_cnt !== 8'd0) $display("FAIL drop_cnt_clear got %0d want 0", drop_cnt); else n_pass++;
      end
`endif
      if (dout === 1'b1) pulses++;
      tick();
    end
    clear_inputs();
    n_checks++; if (pulses != 8) $display("FAIL ovf_pulses got %0d want 8", pulses); else n_pass++;
  endtask

  task automatic test_random();
    drain();
    for (int r = 0; r < 1500; r++) begin
      din       = ($urandom_range(0, 99) < 45);
      cfg_load  = ($urandom_range(0, 99) < 4);
      cfg_delay = CNT_W'($urandom_range(0, 40));
      ovf_clr   = ($urandom_range(0, 99) < 5);
      n_checks++; if (dout !== exp_dout()) $display("FAIL rand_dout cyc=%0d got %b want %b", cyc, dout, exp_dout()); else n_pass++;
      n_checks++; if (pending_cnt !== CW'(mq.size())) $display("FAIL rand_pending cyc=%0d got %0d want %0d", cyc, pending_cnt, mq.size()); else n_pass++;
      n_checks++; if (busy !== (mq.size() != 0)) $display("FAIL rand_busy cyc=%0d got %b want %b", cyc, busy, mq.size() != 0); else n_pass++;
      n_checks++; if (ovf !== m_ovf) $display("FAIL rand_ovf cyc=%0d got %b want %b", cyc, ovf, m_ovf); else n_pass++;
      n_checks++; if (active_delay !== CNT_W'(m_active)) $display("FAIL rand_active cyc=%0d got %0d want %0d", cyc, active_delay, m_active); else n_pass++;
      n_checks++; if (load_pend !== m_pend) $display("FAIL rand_load_pend cyc=%0d got %b want %b", cyc, load_pend, m_pend); else n_pass++;
`ifdef PULSE_DELAY_SCHED_DROP_CNT_EN
      n_checks++; if (drop_cnt !== 8'(m_dropc)) $display("FAIL rand_drop_cnt cyc=%0d got %0d want %0d", cyc, drop_cnt, m_dropc); else n_pass++;
`endif
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_reset_midflight();
    drain();
    for (int r = 0; r <= 25; r++) begin
      cfg_load  = (r == 0);
      cfg_delay = CNT_W'(10);
      din       = (r >= 2 && r <= 4);
      rst_n     = (r != 6);
      if (r == 5) begin
        n_checks++; if (pending_cnt !== CW'(3)) $display("FAIL mid_inflight got %0d want 3", pending_cnt); else n_pass++;
      end
      if (r == 7) begin
        n_checks++; if (busy !== 1'b0 || pending_cnt !== '0 || active_delay !== CNT_W'(DEF_DELAY))
          $display("FAIL mid_reset busy=%b pending=%0d active=%0d want 0 0 %0d", busy, pending_cnt, active_delay, DEF_DELAY);
        else n_pass++;
      end
      if (r >= 7) begin
        n_checks++; if (dout !== 1'b0) $display("FAIL mid_dout r=%0d got %b want 0", r, dout); else n_pass++;
      end
      tick();
    end
    clear_inputs();
    rst_n = 1'b1;
  endtask

  initial begin
    cyc      = 0;
    n_checks = 0;
    n_pass   = 0;
    m_active = DEF_DELAY;
    m_shadow = DEF_DELAY;
    m_pend   = 1'b0;
    m_ovf    = 1'b0;
    m_dropc  = 0;
    rst_n    = 1'b0;
    clear_inputs();
    @(negedge clk);
    test_reset();
    test_single();
    test_long_delay();
    test_wrap();
    test_clamp();
    test_deferred();
    test_overflow();
    test_random();
    test_reset_midflight();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
